// File: rtl/mask_dec16_pkg.sv
// rtl/mask_dec16_pkg.sv - shared widths, FSM encodings and scan flag type for mask_dec16
package mask_dec16_pkg;

    localparam int WIDTH = 16;
    localparam int CW    = 4;

    // 2'd3 is unused and steers back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Per-word scan flags carried from bit to bit
    typedef struct packed {
        logic found;      // select mode: a set bit has been seen
        logic seen_zero;  // mask mode: a clear bit has been seen
        logic err;        // word is not a legal code for its mode
    } flags_t;

    // Index of the last bit in the scan
    function automatic logic [CW-1:0] last_idx();
        return CW'(WIDTH - 1);
    endfunction

endpackage

// File: rtl/mask_dec16_step.sv
// rtl/mask_dec16_step.sv - one-bit decode update shared by select and mask modes
module mask_dec_step
    import mask_dec16_pkg::*;
(
    input  logic          bit_i,
    input  logic [CW-1:0] k_i,
    input  logic          s_i,
    input  flags_t        flags_i,
    input  logic [CW-1:0] c_i,
    output flags_t        flags_o,
    output logic [CW-1:0] c_o
);

    // Fold bit k into the running flags and count/index
    always_comb begin
        flags_o = flags_i;
        c_o     = c_i;
        if (s_i) begin
            // Select mode: last set bit wins, a second set bit is illegal
            if (bit_i) begin
                if (flags_i.found) begin
                    flags_o.err = 1'b1;
                end
                flags_o.found = 1'b1;
                c_o           = k_i;
            end
        end else begin
            // Mask mode: ones must be contiguous from bit 0; bit 15 can never be
            // part of a legal code and pins c at its maximum instead of wrapping
            if (bit_i) begin
                if (k_i == last_idx()) begin
                    flags_o.err = 1'b1;
                    c_o         = last_idx();
                end else if (flags_i.seen_zero) begin
                    flags_o.err = 1'b1;
                end else begin
                    c_o = c_i + CW'(1);
                end
            end else begin
                flags_o.seen_zero = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mask_dec16.sv
// rtl/mask_dec16.sv - bit-serial one-hot/thermometer decoder with valid/ready handshake
module mask_dec16 #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m,
    input  logic             s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    c,
    output logic             z,
    output logic             err
);

    import mask_dec16_pkg::*;

    state_e           state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             s_q, s_d;
    flags_t           flags_q, flags_d;
    logic [CW-1:0]    c_q, c_d;
    logic             z_q, z_d;

    flags_t           step_flags;
    logic [CW-1:0]    step_c;

    mask_dec_step u_step (
        .bit_i   (m_q[k_q]),
        .k_i     (k_q),
        .s_i     (s_q),
        .flags_i (flags_q),
        .c_i     (c_q),
        .flags_o (step_flags),
        .c_o     (step_c)
    );

    // Next-state: capture in IDLE, one bit per clock in SCAN, hold in DONE
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        m_d     = m_q;
        s_d     = s_q;
        flags_d = flags_q;
        c_d     = c_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = m;
                    s_d     = s;
                    flags_d = '0;
                    c_d     = '0;
                    z_d     = 1'b0;
                    k_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                flags_d = step_flags;
                c_d     = step_c;
                k_d     = k_q + CW'(1);
                if (k_q == CW'(WIDTH - 1)) begin
                    z_d     = (m_q == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            m_q     <= '0;
            s_q     <= 1'b0;
            flags_q <= '0;
            c_q     <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
            s_q     <= s_d;
            flags_q <= flags_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign z         = z_q;
    assign err       = flags_q.err;

endmodule

// File: tb/tb_mask_dec16.sv
// tb/tb_mask_dec16.sv - randomized self-checking bench for mask_dec16
module tb_mask_dec16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] m = '0;
    logic        s = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  c;
    logic        z;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic        exp_active = 1'b0;
    logic [3:0]  exp_c;
    logic        exp_z;
    logic        exp_err;

    always #5 clk = ~clk;

    mask_dec16 #(.WIDTH(16), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .z         (z),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference decode: select = highest set bit, legal iff at most one bit set;
    // mask = length of the run of ones from bit 0, legal iff nothing above the run
    // and bit 15 clear; bit 15 set pins c to 15.
    function automatic void model(input logic [15:0] mm, input logic ss,
                                  output logic [3:0] cc, output logic zz, output logic ee);
        int hi;
        int lead;
        zz = (mm == 16'h0);
        if (ss) begin
            hi = 0;
            for (int i = 0; i < 16; i++) if (mm[i]) hi = i;
            cc = 4'(hi);
            ee = ($countones(mm) > 1);
        end else begin
            lead = 0;
            while (lead < 16 && mm[lead]) lead++;
            ee = ({16'h0, mm} != ((32'd1 << lead) - 32'd1)) || mm[15];
            cc = mm[15] ? 4'd15 : 4'(lead);
        end
    endfunction

    // Compare process: whenever a result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_active) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("c", 32'(c), 32'(exp_c));
                chk("z", 32'(z), 32'(exp_z));
                chk("err", 32'(err), 32'(exp_err));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [15:0] mm, input logic ss, input int hold);
        int lat;
        wait_ready();
        model(mm, ss, exp_c, exp_z, exp_err);
        m = mm;
        s = ss;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_active = 1'b1;
        in_valid = $urandom_range(0, 1);
        m = 16'($urandom);
        s = $urandom_range(0, 1);
        lat = 0;
        while (lat < 20) begin
            out_ready = $urandom_range(0, 1);
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'd16);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_active = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic pin(input string name, input logic [15:0] mm, input logic ss,
                       input logic [3:0] wc, input logic wz, input logic we);
        logic [3:0] cc;
        logic zz;
        logic ee;
        model(mm, ss, cc, zz, ee);
        chk({name, "_c"}, 32'(cc), 32'(wc));
        chk({name, "_z"}, 32'(zz), 32'(wz));
        chk({name, "_err"}, 32'(ee), 32'(we));
        send(mm, ss, 0);
    endtask

    initial begin
        logic [15:0] mm;
        int n;
        int seen;

        // Reset state, checked while reset is held
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed expectations
        pin("sel_0400", 16'h0400, 1'b1, 4'd10, 1'b0, 1'b0);
        pin("msk_007f", 16'h007F, 1'b0, 4'd7, 1'b0, 1'b0);
        pin("msk_0000", 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0);
        pin("sel_0081", 16'h0081, 1'b1, 4'd7, 1'b0, 1'b1);
        pin("msk_ffff", 16'hFFFF, 1'b0, 4'd15, 1'b0, 1'b1);
        pin("sel_0000", 16'h0000, 1'b1, 4'd0, 1'b1, 1'b0);
        begin
            logic [3:0] cc;
            logic zz;
            logic ee;
            model(16'h0005, 1'b0, cc, zz, ee);
            chk("msk_0005_err", 32'(ee), 32'd1);
            send(16'h0005, 1'b0, 0);
        end

        // Backpressure
        send(16'h0010, 1'b1, 10);

        // Round trip of every legal code in both modes
        for (int i = 0; i < 16; i++) begin
            send(16'(32'd1 << i), 1'b1, 0);
            send(16'((32'd1 << i) - 32'd1), 1'b0, 0);
        end

        // Reset mid-scan after the eighth scan edge
        wait_ready();
        m = 16'h00FF;
        s = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_c", 32'(c), 32'd0);
        chk("midrst_z", 32'(z), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);

        // Randomized words
        for (int t = 0; t < 60; t++) begin
            n = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: mm = 16'($urandom);
                1: mm = 16'(32'd1 << n);
                2: mm = 16'((32'd1 << n) - 32'd1);
                default: mm = 16'((32'd1 << n) - 32'd1) ^ 16'(32'd1 << $urandom_range(0, 15));
            endcase
            send(mm, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/mask_dec16.md
MASK_DEC16 -- requirements
Module: mask_dec16

Interface
REQ-001 Parameter WIDTH, default 16, mask width in bits; only 16 is supported.
REQ-002 Parameter CW, default 4, count/index width, equal to log2(WIDTH).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  m and s are valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 m  input  16  mask to decode; bit 15 is MSB.
REQ-008 s  input  1  1 = select mode (one-hot to index), 0 = mask mode (thermometer to count).
REQ-009 out_valid  output  1  c, z and err are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 c  output  4  decoded bit index or bit count.
REQ-012 z  output  1  captured mask was all zeros.
REQ-013 err  output  1  captured mask is not a legal code for the captured mode.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-015 in_ready SHALL equal 1 only in IDLE, and out_valid SHALL equal 1 only in DONE.
REQ-016 In IDLE, in_valid=1 SHALL capture m and s, clear c, z and err and the scan flags, load bit counter k=0, and move to SCAN.
REQ-017 In SCAN, each clock SHALL process captured bit k (k = 0..15 ascending), then increment k.
REQ-018 The FSM SHALL move to DONE on the edge that processes k=15.
REQ-019 out_valid SHALL rise exactly 16 rising edges after the accepting edge, regardless of data.
REQ-020 Select mode (s=1), for each set bit k: if a set bit was already found, err=1; then c=k and found=1. Net result: c = index of the highest set bit.
REQ-021 Mask mode (s=0): a set bit SHALL raise err if a zero bit was already seen; otherwise c increments.
REQ-022 Mask mode: a clear bit SHALL set seen_zero.
REQ-023 Mask mode: bit 15 set SHALL force err=1 and c=15; c SHALL never wrap.
REQ-024 z SHALL be 1 in DONE iff the captured m == 0; c SHALL then be 0 and err 0 in both modes.
REQ-025 Legal codes SHALL round-trip: select mode gives c = n for m = 1<<n; mask mode gives c = n for m = (1<<n)-1, n = 0..15.
REQ-026 In DONE, c, z and err SHALL hold stable until out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-027 in_valid SHALL be ignored outside IDLE.
REQ-028 m and s SHALL not be resampled during SCAN; input changes after capture SHALL have no effect.
REQ-029 Minimum spacing between accepted words SHALL be 18 clocks: accept, 16 scan edges, DONE handshake, then IDLE.
REQ-030 out_ready asserted in IDLE or SCAN SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force: IDLE, in_ready=1 (in IDLE per REQ-015), out_valid=0, c=0, z=0, err=0, k=0, all captured data and flags 0.
REQ-032 Reset during SCAN or DONE SHALL discard the word in progress; no out_valid SHALL appear for it after release.
REQ-033 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Structure
REQ-034 A shared package/include SHALL hold WIDTH, CW, and the state encodings IDLE=2'd0, SCAN=2'd1, DONE=2'd2 (2'd3 returns to IDLE).
REQ-035 The per-bit update SHALL be factored into one combinational sub-module, mask_dec_step. Inputs: bit, k, s, flags, c. Outputs: next flags and next c.
REQ-036 Estimated size is under 200 LUTs/FFs; no multipliers or RAM.

Verification
REQ-037 s=1, m=16'h0400, accepted at edge E0: out_valid rises at E16 with c=10, z=0, err=0.
REQ-038 s=0, m=16'h007F: c=7, err=0. s=0, m=16'h0000: c=0, z=1, err=0.
REQ-039 Illegal codes: s=1, m=16'h0081 gives c=7, err=1. s=0, m=16'h0005 gives err=1. s=0, m=16'hFFFF gives c=15, err=1.
REQ-040 Backpressure: hold out_ready=0 for 10 clocks in DONE; outputs stay stable and in_ready stays 0. out_ready=1 at the next edge gives IDLE, then in_ready=1.
REQ-041 Reset: assert rst_n=0 at scan edge 8 of a word. All outputs go 0 and in_ready goes 1 without a clock, and no result for that word appears.
REQ-042 Round-trip: for every n = 0..15 and s = 0/1, the mask16 encoding of (c=n, s) gives decoded c=n and err=0. z=1 only for s=0, n=0.
